// File: rtl/dsram_responder_pkg.sv
// rtl/dsram_responder_pkg.sv - shared widths, state encoding and defaults for the data-SRAM responder
package dsram_responder_pkg;

  localparam int DATA_W             = 32;
  localparam int WEN_W              = 4;
  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 10;
  localparam int DEFAULT_LATENCY    = 0;
  localparam int DEFAULT_CNT_W      = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // A write enable of all zeros means the access is a read.
  function automatic logic is_read(input logic [WEN_W-1:0] wen);
    return (wen == '0);
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// rtl/dsram_responder_if.sv - CPU data-SRAM request/response bundle
interface dsram_responder_if;
  import dsram_responder_pkg::*;

  logic              data_sram_en;
  logic [WEN_W-1:0]  data_sram_wen;
  logic [DATA_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              stallreq;

  // Pipeline side: issues the access, consumes read data and the stall request.
  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq
  );

  // Memory side.
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq
  );

endinterface

// File: rtl/dsram_bytelane_ram.sv
// rtl/dsram_bytelane_ram.sv - four byte-wide synchronous arrays with a registered 32-bit read word
module dsram_bytelane_ram
  import dsram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WEN_W-1:0]      we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  for (genvar l = 0; l < WEN_W; l++) begin : g_lane
    logic [BYTE_W-1:0] mem [DEPTH];

    // Byte lane write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
      if (we_i[l]) begin
        mem[idx_i] <= wdata_i[BYTE_W*l +: BYTE_W];
      end
    end

    assign rd_word[BYTE_W*l +: BYTE_W] = mem[idx_i];
  end

  // Read word only updates on a completed read; writes leave it holding.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_word;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - data-SRAM responder with optional wait states and stall request
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  dsram_responder_if.slave   bus
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [WEN_W-1:0]      wen_q, wen_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  stall_q, stall_d;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [WEN_W-1:0]      ram_we;
  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [DATA_W-1:0]     ram_wdata;
  logic                  unused_addr_bits;

  // Byte offset and high address bits alias onto the same word.
  assign req_idx          = bus.data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.data_sram_addr[DATA_W-1:DEPTH_LOG2+2], bus.data_sram_addr[1:0]};

  // Next state, request capture, wait counting and the memory access strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    stall_d   = stall_q;
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.data_sram_en) begin
          idx_d   = req_idx;
          wen_d   = bus.data_sram_wen;
          wdata_d = bus.data_sram_wdata;
          if (LATENCY == 0) begin
            // Zero-latency: access the array directly from the live request.
            ram_idx   = req_idx;
            ram_wdata = bus.data_sram_wdata;
            ram_we    = bus.data_sram_wen;
            ram_re    = is_read(bus.data_sram_wen);
            stall_d   = 1'b0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
            stall_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Held request inputs are ignored; the captured copy is used.
        if (cnt_q == '0) begin
          ram_we  = wen_q;
          ram_re  = is_read(wen_q);
          state_d = ST_IDLE;
          stall_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
    endcase

    // A reset on the commit cycle aborts the access before anything is written.
    if (rst) begin
      ram_we = '0;
    end
  end

  // State, counter and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      stall_q <= stall_d;
    end
  end

  dsram_bytelane_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (ram_idx),
    .wdata_i (ram_wdata),
    .rdata_o (bus.data_sram_rdata)
  );

  assign bus.stallreq = stall_q;

endmodule
